// File: rtl/exe_pkg.sv
// Shared types for the result buffer: per-entry status flags, occupancy
// states and the error-counter width.
package exe_pkg;

  localparam int ERR_CNT_W = 8;

  typedef struct packed {
    logic zero;
    logic negative;
    logic error;
  } flags_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/wynik_fifo_mem.sv
// Buffer storage: DEPTH x DW register array, one synchronous write port and
// one asynchronous read port. Contents are not reset; the control masks them.
module wynik_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int DW    = 36,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/wynik_bufor.sv
// First-word-fall-through buffer for conversion results with push-time flags.
// Define WYNIK_BUFOR_ERRCNT_EN to build the saturating accepted-error counter.
module wynik_bufor
  import exe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_result,
  input  logic                       i_error,
  output logic                       o_ready,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_result,
  output logic                       o_error,
  output logic [2:0]                 o_flags,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [ERR_CNT_W-1:0]       o_err_cnt,
  output logic [1:0]                 o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = WIDTH + 4;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; o_ready/o_valid depend only on the occupancy state, never on inputs.
  occ_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push, pop;
  flags_t        wr_flags;
  logic [MW-1:0] wr_data, rd_data;

  assign o_ready = (state_q != ST_FULL);
  assign o_valid = (state_q != ST_EMPTY);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    wr_flags.zero     = (i_result == '0) && !i_error;
    wr_flags.negative = i_result[WIDTH-1];
    wr_flags.error    = i_error;
  end

  assign wr_data = {wr_flags, i_error, i_result};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({push, pop})
      2'b10: begin
        count_d  = count_q + CW'(1);
        wr_ptr_d = wr_ptr_q + AW'(1);
        state_d  = (count_q == CW'(DEPTH - 1)) ? ST_FULL : ST_PARTIAL;
      end
      2'b01: begin
        count_d  = count_q - CW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
        state_d  = (count_q == CW'(1)) ? ST_EMPTY : ST_PARTIAL;
      end
      2'b11: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  wynik_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (MW),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (rd_data)
  );

  // Stale storage is hidden whenever the buffer holds nothing.
  assign o_result = o_valid ? rd_data[WIDTH-1:0]  : '0;
  assign o_error  = o_valid ? rd_data[WIDTH]      : 1'b0;
  assign o_flags  = o_valid ? rd_data[MW-1 -: 3]  : 3'b000;
  assign o_count  = count_q;
  assign o_state  = state_q;

`ifdef WYNIK_BUFOR_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && i_error && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: doc/wynik_bufor.md
WYNIK_BUFOR -- requirements
Module: wynik_bufor

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, giving the data width of the conversion result.
REQ-002 The block SHALL have a parameter DEPTH, default 4, giving the number of buffer entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port i_valid, input, 1 bit: the upstream conversion stage presents a result.
REQ-006 Port i_result, input, WIDTH bits: the conversion result from upstream.
REQ-007 Port i_error, input, 1 bit: the conversion error flag from upstream.
REQ-008 Port o_ready, output, 1 bit: the buffer can accept an entry.
REQ-009 Port o_valid, output, 1 bit: the head entry is available downstream.
REQ-010 Port i_ready, input, 1 bit: the downstream stage accepts the head entry.
REQ-011 Port o_result, output, WIDTH bits: the head result.
REQ-012 Port o_error, output, 1 bit: the head error flag.
REQ-013 Port o_flags, output, 3 bits: the head status {zero, negative, error}.
REQ-014 Port o_count, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-015 Port o_err_cnt, output, 8 bits: the accepted-error counter (see Configuration).

Function
REQ-016 A push SHALL occur when i_valid and o_ready are both 1; a pop SHALL occur when o_valid and i_ready are both 1.
REQ-017 o_ready SHALL be 1 exactly when o_count is less than DEPTH; when the buffer is full, a push is not accepted, even if a pop occurs in the same cycle.
REQ-018 o_valid SHALL be 1 exactly when o_count is not 0 (first-word-fall-through); a push into an empty buffer SHALL appear at the outputs one cycle later.
REQ-019 Entries SHALL leave in FIFO order; read and write pointers SHALL wrap modulo DEPTH.
REQ-020 A simultaneous push and pop SHALL leave o_count unchanged.
REQ-021 Flags SHALL be computed at push time: zero = (i_result==0) and not i_error; negative = i_result[WIDTH-1]; error = i_error.
REQ-022 When the buffer is empty, o_result, o_error and o_flags SHALL be driven to 0.
REQ-023 The occupancy state SHALL be EMPTY (count 0), PARTIAL, or FULL (count DEPTH); only push-only and pop-only cycles change the state, by one step.
REQ-024 Stimulus on i_valid while i_rst_n is low SHALL be ignored.

Reset
REQ-025 While i_rst_n is low: pointers = 0, o_count = 0, o_valid = 0, o_ready = 1, o_result/o_error/o_flags = 0, o_err_cnt = 0; the effect SHALL be asynchronous and SHALL discard any buffered entries.
REQ-026 A push SHALL be accepted on the first rising edge after i_rst_n is released.

Configuration
REQ-027 With the macro WYNIK_BUFOR_ERRCNT_EN defined, o_err_cnt SHALL increment on every push with i_error=1 and saturate at 255.
REQ-028 Without WYNIK_BUFOR_ERRCNT_EN, o_err_cnt SHALL be tied to 0 and no counter register SHALL be synthesized.

Structure
REQ-029 The shared package exe_pkg SHALL hold the flags struct type (zero, negative, error) and the error-counter width constant (8).
REQ-030 Storage SHALL be one sub-module, wynik_fifo_mem (DEPTH x (WIDTH+4) register array, one write port, one asynchronous read port); control SHALL remain in wynik_bufor.

Verification (WIDTH=32, DEPTH=4)
REQ-031 Reset pulse -> o_valid=0, o_ready=1, o_count=0, o_result=0, o_err_cnt=0.
REQ-032 Push 0x0000_0005 with i_error=0 and i_ready=0 -> next cycle: o_valid=1, o_result=0x5, o_flags=3'b000, o_count=1.
REQ-033 Push 0x0, 0x1, 0x2, 0x3, then 0x4, with i_ready=0 -> o_ready=0 after the 4th push; 0x4 is dropped; with i_ready=1, pops in order 0x0, 0x1, 0x2, 0x3 (first entry has flags 3'b100).
REQ-034 Push 0x8000_0000 with i_error=1 -> o_error=1, o_flags=3'b011; o_err_cnt=1 with the macro, 0 without; 300 error pushes -> o_err_cnt=255.
REQ-035 With count=2, push and pop in the same cycle -> count stays 2 and the order is preserved; with count=4, push and pop together -> count becomes 3.
REQ-036 With count=3, drive i_rst_n low mid-cycle -> o_valid=0 and o_count=0 immediately, before the next edge.
